alu_md: RTL and testbench

Parametrised successor ALU for the MIPS datapaths. It computes the ALU ops combinationally in the same cycle, including signed overflow detection and a proper signed and unsigned set-less-than. It adds an iterative multiply/divide unit with architectural HI/LO registers and a start/busy/done handshake. The block sits in the execute stage; the control unit stalls the PC while `busy` is high.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_md_if.sv | 35 +++
 rtl/md_unit.sv | 167 ++++++++++++++++
 rtl/alu_md.sv | 86 ++++++++
 tb/tb_alu_md.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, multiply/divide FSM states and helpers for the alu_md execute-stage ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_OR    = 4'd2;
    localparam logic [3:0] ALU_AND   = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOR   = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_SLTU  = 4'd7;
    localparam logic [3:0] ALU_MULTU = 4'd8;
    localparam logic [3:0] ALU_MULT  = 4'd9;
    localparam logic [3:0] ALU_DIVU  = 4'd10;
    localparam logic [3:0] ALU_DIV   = 4'd11;
    localparam logic [3:0] ALU_MFHI  = 4'd12;
    localparam logic [3:0] ALU_MFLO  = 4'd13;
    localparam logic [3:0] ALU_MTHI  = 4'd14;
    localparam logic [3:0] ALU_MTLO  = 4'd15;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

    // MULTU, MULT, DIVU and DIV occupy opcodes 8..11.
    function automatic logic is_md_op(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_md_if.sv
// Bundle of the ALU operand/result and multiply/divide handshake signals.
interface alu_md_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
);
    // Handshake: a multiply/divide is accepted on any rising edge where start=1,
    // busy=0 and aluop is 8..11; busy then stays high until HI/LO are written,
    // and done pulses for the single cycle after that write. start is ignored
    // while busy=1, and may be raised again in the done cycle for back-to-back ops.
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       aluop;
    logic             flagsel;
    logic             start;
    logic [WIDTH-1:0] aluout;
    logic             zero;
    logic             flag;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    md_state_t        md_state;

    modport master (
        output a, b, aluop, flagsel, start,
        input  aluout, zero, flag, busy, done, hi, lo, md_state
    );

    modport slave (
        input  a, b, aluop, flagsel, start,
        output aluout, zero, flag, busy, done, hi, lo, md_state
    );

endinterface

// File: rtl/md_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, sign
// fix-up on magnitudes, and the architectural HI/LO registers.
module md_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       aluop_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output md_state_t        state_o
);

    md_state_t        state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    // acc holds the product high half / partial remainder, sh the product low
    // half / quotient, opd the multiplicand / divisor magnitude.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [WIDTH-1:0] a_orig_q, a_orig_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic               op_signed;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opd_q} : '0);
        div_shift = {acc_q, sh_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opd_q};
        div_ge    = div_shift >= {1'b0, opd_q};
        prod      = neg_q ? -{acc_q, sh_q} : {acc_q, sh_q};
        quo       = neg_q ? -sh_q : sh_q;
        rem       = rem_neg_q ? -acc_q : acc_q;
        op_signed = aluop_i[0];
        mag_a     = (op_signed && a_i[WIDTH-1]) ? -a_i : a_i;
        mag_b     = (op_signed && b_i[WIDTH-1]) ? -b_i : b_i;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        acc_d     = acc_q;
        sh_d      = sh_q;
        opd_d     = opd_q;
        a_orig_d  = a_orig_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;

        case (state_q)
            MD_IDLE: begin
                if (start_i && is_md_op(aluop_i)) begin
                    acc_d     = '0;
                    sh_d      = mag_a;
                    opd_d     = mag_b;
                    a_orig_d  = a_i;
                    is_div_d  = aluop_i[1];
                    neg_d     = op_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    rem_neg_d = op_signed && a_i[WIDTH-1];
                    dz_d      = (b_i == '0);
                    cnt_d     = CNTW'(WIDTH);
                    state_d   = MD_RUN;
                end else if (aluop_i == ALU_MTHI) begin
                    hi_d = a_i;
                end else if (aluop_i == ALU_MTLO) begin
                    lo_d = a_i;
                end
            end
            MD_RUN: begin
                if (cnt_q == '0) begin
                    state_d = MD_FIX;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                    if (is_div_q) begin
                        acc_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        sh_d  = {sh_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_d = mul_sum[WIDTH:1];
                        sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
                    end
                end
            end
            MD_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (dz_q) begin
                    // Divide by zero is defined rather than trapped.
                    hi_d = a_orig_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
                done_d  = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            acc_q     <= '0;
            sh_q      <= '0;
            opd_q     <= '0;
            a_orig_q  <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            opd_q     <= opd_d;
            a_orig_q  <= a_orig_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
        end
    end

    assign busy_o  = (state_q != MD_IDLE);
    assign done_o  = done_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign state_o = state_q;

endmodule

// File: rtl/alu_md.sv
// Execute-stage ALU: same-cycle arithmetic/logic ops with overflow and
// set-less-than, plus the iterative multiply/divide unit and HI/LO access.
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input logic       clk,
    input logic       reset,
    alu_md_if.slave   bus
);

    logic [WIDTH-1:0] hi_w;
    logic [WIDTH-1:0] lo_w;
    logic             busy_w;
    logic             done_w;
    md_state_t        state_w;

    md_unit #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_md (
        .clk     (clk),
        .reset   (reset),
        .a_i     (bus.a),
        .b_i     (bus.b),
        .aluop_i (bus.aluop),
        .start_i (bus.start),
        .busy_o  (busy_w),
        .done_o  (done_w),
        .hi_o    (hi_w),
        .lo_o    (lo_w),
        .state_o (state_w)
    );

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic             ovf_add;
    logic             ovf_sub;
    logic             slt;
    logic             sltu;
    logic [WIDTH-1:0] res;
    logic             flg;

    always_comb begin
        sum     = bus.a + bus.b;
        dif     = bus.a - bus.b;
        ovf_add = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        ovf_sub = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
        // True signed compare, so SLT stays correct when the difference overflows.
        slt     = $signed(bus.a) < $signed(bus.b);
        sltu    = bus.a < bus.b;
        res     = '0;
        flg     = 1'b0;
        case (bus.aluop)
            ALU_ADD: begin
                res = sum;
                flg = bus.flagsel && ovf_add;
            end
            ALU_SUB: begin
                res = dif;
                flg = bus.flagsel && ovf_sub;
            end
            ALU_OR:   res = bus.a | bus.b;
            ALU_AND:  res = bus.a & bus.b;
            ALU_XOR:  res = bus.a ^ bus.b;
            ALU_NOR:  res = ~(bus.a | bus.b);
            ALU_SLT:  res = {{(WIDTH-1){1'b0}}, slt};
            ALU_SLTU: res = {{(WIDTH-1){1'b0}}, sltu};
            ALU_MFHI: res = hi_w;
            ALU_MFLO: res = lo_w;
            default:  res = '0;
        endcase
    end

    assign bus.aluout   = res;
    assign bus.zero     = (res == '0);
    assign bus.flag     = flg;
    assign bus.busy     = busy_w;
    assign bus.done     = done_w;
    assign bus.hi       = hi_w;
    assign bus.lo       = lo_w;
    assign bus.md_state = state_w;

endmodule

// File: tb/tb_alu_md.sv
// Bench for alu_md: directed corner cases plus random operands checked against
// an arithmetic reference model of the ALU and of HI/LO.
module tb_alu_md;
    import alu_pkg::*;

    localparam int W = 32;
    localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint SMIN = -64'sh0000_0000_8000_0000;

    logic         clk = 1'b0;
    logic         reset;
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic [W-1:0] corners [6];

    alu_md_if #(.WIDTH(W)) bus ();

    alu_md #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic fs);
        bus.aluop   = op;
        bus.a       = a;
        bus.b       = b;
        bus.flagsel = fs;
        #1;
    endtask

    function automatic void ref_comb(input logic [3:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic fs,
                                     input logic [W-1:0] hi, input logic [W-1:0] lo,
                                     output logic [W-1:0] out, output logic flg);
        longint sa, sb, ua, ub, r;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        r   = 0;
        out = '0;
        flg = 1'b0;
        case (op)
            ALU_ADD: begin
                r = sa + sb;
                out = r[31:0];
                flg = fs && (r > SMAX || r < SMIN);
            end
            ALU_SUB: begin
                r = sa - sb;
                out = r[31:0];
                flg = fs && (r > SMAX || r < SMIN);
            end
            ALU_OR:   out = a | b;
            ALU_AND:  out = a & b;
            ALU_XOR:  out = a ^ b;
            ALU_NOR:  out = ~(a | b);
            ALU_SLT:  out = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: out = (ua < ub) ? 32'd1 : 32'd0;
            ALU_MFHI: out = hi;
            ALU_MFLO: out = lo;
            default:  out = '0;
        endcase
    endfunction

    function automatic void ref_md(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output logic [W-1:0] h, output logic [W-1:0] l);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        p  = '0;
        h  = '0;
        l  = '0;
        case (op)
            ALU_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                h = p[63:32];
                l = p[31:0];
            end
            ALU_MULT: begin
                p = sa * sb;
                h = p[63:32];
                l = p[31:0];
            end
            ALU_DIVU: begin
                if (b == '0) begin
                    h = a;
                    l = '1;
                end else begin
                    h = a % b;
                    l = a / b;
                end
            end
            ALU_DIV: begin
                if (b == '0) begin
                    h = a;
                    l = '1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    h = '0;
                    l = 32'h8000_0000;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    h = r[31:0];
                    l = q[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    task automatic check_comb(input string tag);
        logic [W-1:0] eo;
        logic         ef;
        ref_comb(bus.aluop, bus.a, bus.b, bus.flagsel, exp_hi, exp_lo, eo, ef);
        check({tag, ".out"}, bus.aluout, eo);
        check({tag, ".zero"}, W'(bus.zero), W'(eo == '0));
        check({tag, ".flag"}, W'(bus.flag), W'(ef));
    endtask

    // Launch one multiply/divide and follow it to completion; must be entered
    // with the unit idle or in its done cycle.
    task automatic run_md(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit disturb);
        logic [W-1:0] eh, el;
        int n;
        ref_md(op, a, b, eh, el);
        bus.aluop = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            if (disturb) begin
                case (n)
                    3: begin
                        bus.aluop = ALU_MFHI;
                        #1;
                        check({tag, ".mfhi_busy"}, bus.aluout, exp_hi);
                    end
                    5: begin
                        bus.aluop = ALU_DIVU;
                        bus.a     = $urandom();
                        bus.b     = $urandom();
                        bus.start = 1'b1;
                    end
                    6: begin
                        bus.start = 1'b0;
                        bus.aluop = op;
                    end
                    8: begin
                        bus.aluop = ALU_MTHI;
                        bus.a     = 32'h1234_5678;
                    end
                    9:  bus.aluop = ALU_MTLO;
                    10: bus.aluop = op;
                    default: ;
                endcase
            end
            tick();
            n++;
        end
        check({tag, ".latency"}, W'(n), W'(W + 2));
        check({tag, ".done"}, W'(bus.done), 32'd1);
        check({tag, ".hi"}, bus.hi, eh);
        check({tag, ".lo"}, bus.lo, el);
        exp_hi = eh;
        exp_lo = el;
    endtask

    initial begin
        int dones;
        logic [W-1:0] ra, rb;
        logic [3:0]   rop;

        corners[0] = 32'h7FFF_FFFF;
        corners[1] = 32'h8000_0000;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h0000_0000;
        corners[4] = 32'h0000_0001;
        corners[5] = 32'h8000_0001;

        reset     = 1'b1;
        bus.a     = '0;
        bus.b     = '0;
        bus.aluop = ALU_ADD;
        bus.flagsel = 1'b0;
        bus.start = 1'b0;
        exp_hi    = '0;
        exp_lo    = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst.hi", bus.hi, '0);
        check("rst.lo", bus.lo, '0);
        check("rst.busy", W'(bus.busy), '0);
        check("rst.done", W'(bus.done), '0);

        drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1);
        check("add_ovf.out", bus.aluout, 32'h8000_0000);
        check("add_ovf.flag", W'(bus.flag), 32'd1);
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0);
        check("add_noflag.flag", W'(bus.flag), 32'd0);
        drive(ALU_SUB, 32'd5, 32'd5, 1'b1);
        check("sub_zero.zero", W'(bus.zero), 32'd1);
        check("sub_zero.flag", W'(bus.flag), 32'd0);
        drive(ALU_SLT, 32'h8000_0000, 32'd1, 1'b0);
        check("slt_neg.out", bus.aluout, 32'd1);
        drive(ALU_SLTU, 32'h8000_0000, 32'd1, 1'b0);
        check("sltu.out", bus.aluout, 32'd0);
        drive(ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        check("slt_ovf.out", bus.aluout, 32'd0);
        drive(ALU_SUB, 32'h8000_0000, 32'd1, 1'b1);
        check("sub_ovf.flag", W'(bus.flag), 32'd1);
        drive(ALU_SLT, 32'h8000_0000, 32'd1, 1'b1);
        check("slt_flagsel.flag", W'(bus.flag), 32'd0);

        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 13));
            ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
            rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
            drive(rop, ra, rb, 1'($urandom_range(0, 1)));
            check_comb("rnd_comb");
        end

        tick();
        drive(ALU_MTHI, 32'hCAFE_F00D, '0, 1'b0);
        tick();
        exp_hi = 32'hCAFE_F00D;
        drive(ALU_MTLO, 32'h0BAD_BEEF, '0, 1'b0);
        tick();
        exp_lo = 32'h0BAD_BEEF;
        drive(ALU_MFHI, '0, '0, 1'b0);
        check_comb("mfhi");
        drive(ALU_MFLO, '0, '0, 1'b0);
        check_comb("mflo");

        tick();
        run_md("mult_neg", ALU_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("mult_neg.hi_const", bus.hi, 32'hFFFF_FFFF);
        check("mult_neg.lo_const", bus.lo, 32'hFFFF_FFFE);
        bus.aluop = ALU_ADD;
        tick();
        check("done_one_cycle", W'(bus.done), 32'd0);
        check("idle_busy", W'(bus.busy), 32'd0);

        run_md("div_neg", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg.lo_const", bus.lo, 32'hFFFF_FFFD);
        check("div_neg.hi_const", bus.hi, 32'hFFFF_FFFF);
        run_md("divu_zero", ALU_DIVU, 32'd7, 32'd0, 1'b0);
        check("divu_zero.lo_const", bus.lo, 32'hFFFF_FFFF);
        check("divu_zero.hi_const", bus.hi, 32'd7);
        run_md("div_min", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_md("div_zero_s", ALU_DIV, 32'hFFFF_FFF7, 32'd0, 1'b0);
        run_md("multu_big", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_md("mult_min", ALU_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_md("disturb", ALU_MULTU, $urandom(), $urandom(), 1'b1);
        run_md("disturb_div", ALU_DIV, $urandom(), 32'($urandom_range(1, 1000)), 1'b1);

        for (int i = 0; i < 12; i++) begin
            rop = 4'($urandom_range(8, 11));
            ra  = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
            rb  = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 5)] : $urandom();
            if (i % 3 == 0) rb = 32'($urandom_range(0, 15));
            run_md("rnd_md", rop, ra, rb, 1'b0);
        end

        bus.aluop = ALU_ADD;
        tick();
        bus.aluop = ALU_MULTU;
        bus.a     = $urandom();
        bus.b     = $urandom();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        check("rst_mid.busy", W'(bus.busy), 32'd0);
        check("rst_mid.hi", bus.hi, exp_hi);
        check("rst_mid.lo", bus.lo, exp_lo);
        check("rst_mid.done", W'(bus.done), 32'd0);
        bus.aluop = ALU_ADD;
        dones = 0;
        repeat (40) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        check("rst_mid.no_done", W'(dones), 32'd0);
        run_md("after_rst", ALU_DIVU, 32'd100, 32'd7, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
